img_frame_arbiter: RTL
======================

IMG_FRAME_ARBITER -- requirements
Module: img_frame_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, max idle cycles allowed while a source is granted.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 4, dead cycles after each frame so the downstream pipeline flushes.
REQ-003 SHALL have port clk_sys  in  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_sys  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port Req  in  2  per-source frame request; bit i for source i.
REQ-006 SHALL have port Grant  out  2  one-hot-or-zero; source i may start its frame while Grant[i]=1.
REQ-007 SHALL have ports In0VSYNC, In0HSYNC, In0EN  in  1 each; In0Data  in  8  stream from source 0.
REQ-008 SHALL have ports In1VSYNC, In1HSYNC, In1EN  in  1 each; In1Data  in  8  stream from source 1.
REQ-009 SHALL have ports OutVSYNC, OutHSYNC, OutEN  out  1 each; OutData  out  8  muxed stream to the shared processing stage.
REQ-010 SHALL have port Owner  out  1  index of the current/last granted source.
REQ-011 SHALL have port Busy  out  1  high in every state except IDLE.
REQ-012 SHALL have port LineCnt  out  16  lines received in the current frame.
REQ-013 SHALL have ports FrameDone, ErrTimeout  out  1 each; single-cycle pulses.

Function
REQ-014 Stream format SHALL be: SOF = VSYNC and HSYNC high together; each line = HSYNC pulse followed by EN-qualified data bytes; EOF = next VSYNC pulse (with HSYNC) after SOF.
REQ-015 Sync events SHALL be detected on rising edges (registered previous value of the selected source's VSYNC/HSYNC).
REQ-016 FSM states SHALL be IDLE, WAIT_SOF, ACTIVE, DRAIN.
REQ-017 IDLE: if any Req set, grant round-robin (the source other than Owner wins when both request), update Owner, go WAIT_SOF.
REQ-018 WAIT_SOF: Grant[Owner]=1; VSYNC rise on owner -> ACTIVE, LineCnt=1; Req[Owner] falling -> IDLE, no output.
REQ-019 ACTIVE: Grant[Owner]=1; HSYNC rise without VSYNC -> LineCnt+1 (saturate at 0xFFFF); VSYNC rise -> forward that EOF beat, FrameDone pulse one cycle after, go DRAIN.
REQ-020 Req deassertion in ACTIVE SHALL be ignored; the frame always completes or times out.
REQ-021 Out* SHALL equal the owner's In* delayed exactly one clock (registered) during WAIT_SOF and ACTIVE, including the SOF and EOF beats; all Out* zero in IDLE and DRAIN.
REQ-022 Non-owner inputs SHALL never affect any output.
REQ-023 Idle counter SHALL reset on any owner VSYNC/HSYNC/EN activity and on state entry; reaching TIMEOUT_CYCLES in WAIT_SOF or ACTIVE -> ErrTimeout pulse, Out* forced zero, go DRAIN, no FrameDone.
REQ-024 DRAIN: Grant=0, hold DRAIN_CYCLES cycles, then IDLE; LineCnt holds its final value until next SOF.
REQ-025 Grant SHALL be combinational from state and Owner; Grant never changes inside a frame.

Reset
REQ-026 reset_sys high SHALL asynchronously force: state IDLE, Grant=0, all Out*=0, Owner=1 (so source 0 wins first), Busy=0, LineCnt=0, FrameDone=0, ErrTimeout=0, counters 0.
REQ-027 Reset mid-frame SHALL abort silently (no FrameDone/ErrTimeout); after release, arbitration restarts from IDLE.

Structure
REQ-028 Shared package img_stream_pkg SHALL hold the FSM state encoding, default TIMEOUT_CYCLES/DRAIN_CYCLES, and the 8-bit data width constant.
REQ-029 Round-robin decision SHALL be a sub-module img_rr_arb2 (Req, Owner -> next owner, valid); the rest stays in img_frame_arbiter.

Verification
REQ-030 Single source: Req=01, 3-line frame of 6 bytes/line (0x10..0x21) -> Grant=01, Out* identical to In0* one clock later, LineCnt=3, one FrameDone, Grant=0 for 4 cycles.
REQ-031 Both request at reset exit -> source 0 frame first, then source 1; a third request from both -> source 0 again; Owner toggles 0,1,0.
REQ-032 Source 1 toggles its inputs during source 0's frame -> Out* bit-exact to source 0 only.
REQ-033 Granted source sends SOF then stalls 4096 cycles -> ErrTimeout pulse at cycle 4096, no FrameDone, Out*=0, return to IDLE after DRAIN.
REQ-034 Req[0] dropped in WAIT_SOF -> IDLE next cycle, no output; Req[0] dropped mid-frame -> frame completes with FrameDone.
REQ-035 reset_sys pulsed mid-line -> all outputs zero immediately, no pulses, clean arbitration afterwards.

Source files
------------

// File: rtl/img_stream_pkg.sv
// Shared types and constants for the two-source video frame arbiter.
// State encoding, default timing parameters and the pixel data width.
package img_stream_pkg;

  localparam int DATA_W      = 8;
  localparam int TIMEOUT_DEF = 4096;
  localparam int DRAIN_DEF   = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2,
    DRAIN    = 2'd3
  } state_t;

endpackage

// File: rtl/img_frame_arbiter_if.sv
// One video stream bundle: sync strobes, enable and pixel byte.
// Used for the owner-selected stream inside the arbiter and by the bench.
interface img_frame_arbiter_if;
  import img_stream_pkg::*;

  logic              VSYNC;
  logic              HSYNC;
  logic              EN;
  logic [DATA_W-1:0] Data;

  modport master (
    output VSYNC, HSYNC, EN, Data
  );

  modport slave (
    input VSYNC, HSYNC, EN, Data
  );

endinterface

// File: rtl/img_rr_arb2.sv
// Two-way round-robin pick: the source that did not own last wins a tie.
// Pure combinational; the caller registers the chosen owner.
module img_rr_arb2 (
  input  logic [1:0] Req,
  input  logic       Owner,
  output logic       nextOwner,
  output logic       valid
);

  always_comb begin
    valid     = |Req;
    nextOwner = Owner;
    unique case (Req)
      2'b11:   nextOwner = ~Owner;
      2'b10:   nextOwner = 1'b1;
      2'b01:   nextOwner = 1'b0;
      default: nextOwner = Owner;
    endcase
  end

endmodule

// File: rtl/img_frame_arbiter.sv
// Grants one of two video sources a whole frame at a time and muxes its
// stream (one clock late) to a shared stage, with timeout and drain gap.
module img_frame_arbiter
  import img_stream_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int DRAIN_CYCLES   = DRAIN_DEF
) (
  input  logic              clk_sys,
  input  logic              reset_sys,
  input  logic [1:0]        Req,
  output logic [1:0]        Grant,
  input  logic              In0VSYNC,
  input  logic              In0HSYNC,
  input  logic              In0EN,
  input  logic [DATA_W-1:0] In0Data,
  input  logic              In1VSYNC,
  input  logic              In1HSYNC,
  input  logic              In1EN,
  input  logic [DATA_W-1:0] In1Data,
  output logic              OutVSYNC,
  output logic              OutHSYNC,
  output logic              OutEN,
  output logic [DATA_W-1:0] OutData,
  output logic              Owner,
  output logic              Busy,
  output logic [15:0]       LineCnt,
  output logic              FrameDone,
  output logic              ErrTimeout
);

  localparam int IW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DCW = $clog2(DRAIN_CYCLES + 1);

  img_frame_arbiter_if sel ();

  state_t          state;
  state_t          stateNext;
  logic            ownerNext;
  logic            arbValid;
  logic            prevV;
  logic            prevH;
  logic            vRise;
  logic            hRise;
  logic            activity;
  logic            inFrame;
  logic            idleHit;
  logic            sofHit;
  logic            eofHit;
  logic            tmoHit;
  logic            outEn;
  logic [IW-1:0]   idleCnt;
  logic [IW-1:0]   idleNext;
  logic [DCW-1:0]  drainCnt;
  logic [DCW-1:0]  drainNext;

  // Only the owner's stream is ever looked at.
  assign sel.VSYNC = Owner ? In1VSYNC : In0VSYNC;
  assign sel.HSYNC = Owner ? In1HSYNC : In0HSYNC;
  assign sel.EN    = Owner ? In1EN    : In0EN;
  assign sel.Data  = Owner ? In1Data  : In0Data;

  assign vRise    = sel.VSYNC & ~prevV;
  assign hRise    = sel.HSYNC & ~prevH;
  assign activity = sel.VSYNC | sel.HSYNC | sel.EN;
  assign inFrame  = (state == WAIT_SOF) || (state == ACTIVE);
  assign idleHit  = inFrame && !activity
                 && (idleCnt == IW'(TIMEOUT_CYCLES - 1));

  img_rr_arb2 uArb (
    .Req       (Req),
    .Owner     (Owner),
    .nextOwner (ownerNext),
    .valid     (arbValid)
  );

  always_comb begin
    stateNext = state;
    sofHit    = 1'b0;
    eofHit    = 1'b0;
    tmoHit    = 1'b0;
    unique case (state)
      IDLE: begin
        if (arbValid) stateNext = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (vRise) begin
          stateNext = ACTIVE;
          sofHit    = 1'b1;
        end else if (!Req[Owner]) begin
          stateNext = IDLE;
        end else if (idleHit) begin
          stateNext = DRAIN;
          tmoHit    = 1'b1;
        end
      end
      ACTIVE: begin
        if (vRise) begin
          stateNext = DRAIN;
          eofHit    = 1'b1;
        end else if (idleHit) begin
          stateNext = DRAIN;
          tmoHit    = 1'b1;
        end
      end
      DRAIN: begin
        if (drainCnt == DCW'(DRAIN_CYCLES - 1)) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    idleNext = (!inFrame || activity || stateNext != state)
             ? '0 : idleCnt + IW'(1);
    drainNext = (state == DRAIN && stateNext == DRAIN)
              ? drainCnt + DCW'(1) : '0;
    // EOF beat still goes out; a timeout or request drop blanks it.
    outEn = inFrame && (stateNext != IDLE) && !tmoHit;

    Grant = inFrame ? (Owner ? 2'b10 : 2'b01) : 2'b00;
    Busy  = (state != IDLE);
  end

  always_ff @(posedge clk_sys or posedge reset_sys) begin
    if (reset_sys) begin
      state      <= IDLE;
      Owner      <= 1'b1;
      prevV      <= 1'b0;
      prevH      <= 1'b0;
      idleCnt    <= '0;
      drainCnt   <= '0;
      LineCnt    <= '0;
      FrameDone  <= 1'b0;
      ErrTimeout <= 1'b0;
      OutVSYNC   <= 1'b0;
      OutHSYNC   <= 1'b0;
      OutEN      <= 1'b0;
      OutData    <= '0;
    end else begin
      state      <= stateNext;
      prevV      <= sel.VSYNC;
      prevH      <= sel.HSYNC;
      idleCnt    <= idleNext;
      drainCnt   <= drainNext;
      FrameDone  <= eofHit;
      ErrTimeout <= tmoHit;
      if (state == IDLE && arbValid) Owner <= ownerNext;
      if (sofHit) begin
        LineCnt <= 16'd1;
      end else if (state == ACTIVE && hRise && !sel.VSYNC
                   && LineCnt != 16'hFFFF) begin
        LineCnt <= LineCnt + 16'd1;
      end
      if (outEn) begin
        OutVSYNC <= sel.VSYNC;
        OutHSYNC <= sel.HSYNC;
        OutEN    <= sel.EN;
        OutData  <= sel.Data;
      end else begin
        OutVSYNC <= 1'b0;
        OutHSYNC <= 1'b0;
        OutEN    <= 1'b0;
        OutData  <= '0;
      end
    end
  end

endmodule
